keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Receive side of the 4x4 keypad matrix interface. Samples the four row lines while the column scanner drives one column high, synchronizes and debounces the row inputs, and resolves the pressed key to a 4-bit hex code. Asserts `button_pressed` back to the scanner so it holds the active column while a key is down, then emits a single-cycle `key_valid` strobe per debounced press.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: clock cycles a row level must be stable to accept a press or a release; minimum value 2.
- `REPEAT_DELAY`, default 500000: cycles from the first strobe to the first auto-repeat strobe. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, default 100000: cycles between later auto-repeat strobes. Used only with `KEYPAD_REPEAT_EN`.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `col_keys` input 4: one-hot column currently driven by the scanner.
- `row_keys` input 4: raw asynchronous keypad rows, active-high.
- `button_pressed` output 1: registered; high while a key is being debounced, is held, or is being release-debounced.
- `key_code` output 4: registered hex code of the last accepted key.
- `key_valid` output 1: registered single-cycle strobe for a new key (or a repeat).

## Operation
- `row_keys` passes through a 2-flop synchronizer. All decisions use the synchronized rows (`row_s`).
- Key map, row r / col c, where col0 = `col_keys[0]`:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- **IDLE**
  - When `row_s` != 0 and `col_keys` is exactly one-hot, capture the lowest-index high row and the column index, clear the counter, and go to DEBOUNCE.
  - A `col_keys` value that is not one-hot (0 or multi-hot) is ignored, and the FSM stays in IDLE.
- **DEBOUNCE**
  - If the captured row is low or `col_keys` differs from the captured column, go to IDLE. No strobe is issued.
  - Otherwise, if counter == `DEBOUNCE_CYCLES`-1, register `key_code`, pulse `key_valid`, and go to HELD.
  - Otherwise, increment the counter.
- **HELD**
  - When the captured row goes low, clear the counter and go to RELEASE.
  - Other rows going high while held are ignored; there is no rollover.
- **RELEASE**
  - If the captured row goes high again, return to HELD with no new strobe.
  - If the row stays low until counter == `DEBOUNCE_CYCLES`-1, go to IDLE.
- `button_pressed` = 1 in DEBOUNCE, HELD and RELEASE, and 0 in IDLE. It is registered together with the state.
- The counter is 32 bits wide, saturates at its terminal value, and is never compared across a wrap.

## Timing
- Reset values: state IDLE, `button_pressed`=0, `key_valid`=0, `key_code`=4'h0, counter 0, synchronizer flops 0.
- Press latency: counting the first edge that samples the row high as edge 0, DEBOUNCE is entered at edge 2. `key_valid` is high for exactly the one cycle after edge `DEBOUNCE_CYCLES`+2. `key_code` is valid in that cycle and holds until the next accepted press.
- `button_pressed` rises after edge 2 and falls after edge `DEBOUNCE_CYCLES`+2 measured from the first low sample of the release.
- A bounce shorter than `DEBOUNCE_CYCLES` never produces a strobe. A release bounce never produces a second strobe.
- Reset asserted mid-operation forces all outputs to their reset values immediately, with no strobe.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - While in HELD, a repeat counter runs.
  - A second `key_valid` strobe with the same `key_code` fires `REPEAT_DELAY` cycles after the original strobe, then one every `REPEAT_PERIOD` cycles.
  - Leaving HELD clears the repeat counter. Time spent in RELEASE does not count.
- `KEYPAD_REPEAT_EN` undefined: exactly one strobe per press; the repeat logic and its parameters are absent.

## Test plan
- `DEBOUNCE_CYCLES`=4, `col_keys`=4'b0010, `row_keys`=4'b0100 held -> single `key_valid` after edge 6, `key_code`=4'h8, `button_pressed` high from edge 2.
- Same column, row 1 pulsed high for 3 cycles then low -> no `key_valid`, `button_pressed` returns to 0.
- Press key 0 (r3, c1), release with a 2-cycle high glitch during RELEASE -> exactly one strobe with `key_code`=4'h0, and IDLE is reached 4 stable-low cycles after the glitch.
- `row_keys`=4'b1010 with `col_keys`=4'b1000 -> `key_code`=4'hB (lowest row wins); `col_keys`=4'b0000 with rows high -> stays IDLE.
- Reset asserted in DEBOUNCE and again in HELD -> `button_pressed`, `key_valid`, `key_code` = 0 immediately, FSM in IDLE.
- With `KEYPAD_REPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, key held 30 cycles past the first strobe -> repeat strobes at +10, +15, +20, +25, +30.

Source files
------------

// File: rtl/keypad_decoder.sv
// Receive side of a 4x4 keypad matrix: synchronizes and debounces the rows and
// strobes the hex code of each accepted press. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_keys,
  input  logic [3:0] row_keys,
  output logic       button_pressed,
  output logic [3:0] key_code,
  output logic       key_valid
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_REPEAT_EN
  localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);
`endif

  state_t      state, state_next;
  logic [31:0] cnt, cnt_next, cnt_inc;
  logic [1:0]  row_idx, row_idx_next;
  logic [1:0]  col_idx, col_idx_next;
  logic [3:0]  key_code_next;
  logic        key_valid_next;
  logic [3:0]  row_meta, row_s;
  logic        col_onehot, row_hit, col_hit;

`ifdef KEYPAD_REPEAT_EN
  logic [31:0] rep_cnt, rep_cnt_next;
  logic        rep_first, rep_first_next;
`endif

  // Index of the lowest set bit; callers only pass non-zero vectors.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [3:0] hex_of(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // Two flops give a metastable first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'd0;
      row_s    <= 4'd0;
    end else begin
      row_meta <= row_keys;
      row_s    <= row_meta;
    end
  end

  assign col_onehot = (col_keys != 4'd0) && ((col_keys & (col_keys - 4'd1)) == 4'd0);
  assign row_hit    = row_s[row_idx];
  assign col_hit    = (col_keys == (4'b0001 << col_idx));
  assign cnt_inc    = (cnt == DB_LAST) ? cnt : cnt + 32'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next     = state;
    cnt_next       = cnt;
    row_idx_next   = row_idx;
    col_idx_next   = col_idx;
    key_code_next  = key_code;
    key_valid_next = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next   = 32'd0;
    rep_first_next = 1'b1;
`endif

    case (state)
      IDLE: begin
        if ((row_s != 4'd0) && col_onehot) begin
          row_idx_next = low_index(row_s);
          col_idx_next = low_index(col_keys);
          cnt_next     = 32'd0;
          state_next   = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (!row_hit || !col_hit) begin
          state_next = IDLE;
        end else if (cnt == DB_LAST) begin
          key_code_next  = hex_of(row_idx, col_idx);
          key_valid_next = 1'b1;
          state_next     = HELD;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      HELD: begin
        if (!row_hit) begin
          cnt_next   = 32'd0;
          state_next = RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          // First repeat waits the long delay, later ones the shorter period.
          rep_first_next = rep_first;
          if (rep_cnt == (rep_first ? RD_LAST : RP_LAST)) begin
            key_valid_next = 1'b1;
            rep_cnt_next   = 32'd0;
            rep_first_next = 1'b0;
          end else begin
            rep_cnt_next = rep_cnt + 32'd1;
          end
        end
`endif
      end

      RELEASE: begin
        if (row_hit) begin
          state_next = HELD;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 32'd0;
      row_idx        <= 2'd0;
      col_idx        <= 2'd0;
      key_code       <= 4'h0;
      key_valid      <= 1'b0;
      button_pressed <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt        <= 32'd0;
      rep_first      <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state          <= state_next;
      cnt            <= cnt_next;
      row_idx        <= row_idx_next;
      col_idx        <= col_idx_next;
      key_code       <= key_code_next;
      key_valid      <= key_valid_next;
      button_pressed <= (state_next != IDLE);
`ifdef KEYPAD_REPEAT_EN
      rep_cnt        <= rep_cnt_next;
      rep_first      <= rep_first_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: directed timing cases plus randomized
// press/bounce/release sequences checked against strobe times derived from the key rules.
module tb_keypad_decoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_keys = 4'b0001;
  logic [3:0] row_keys = 4'b0000;
  logic       button_pressed;
  logic       key_valid;
  logic [3:0] key_code;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         at;
    logic [3:0] code;
  } strobe_t;

  strobe_t exp_q[$];

  keypad_decoder #(
    .DEBOUNCE_CYCLES(D)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_keys(col_keys),
    .row_keys(row_keys),
    .button_pressed(button_pressed),
    .key_code(key_code),
    .key_valid(key_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Hex code of row r / column c, read off the keypad legend.
  function automatic logic [3:0] key_of(input int r, input int c);
    string legend;
    byte   ch;
    legend = "123A456B789CE0FD";
    ch = legend[r * 4 + c];
    if (ch >= 8'h41) return 4'(ch - 8'h37);
    return 4'(ch - 8'h30);
  endfunction

  task automatic expect_strobe(input int at, input logic [3:0] code);
    strobe_t s;
    s.at   = at;
    s.code = code;
    exp_q.push_back(s);
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] c, input int n);
    row_keys = r;
    col_keys = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Every strobe must land on a predicted cycle, and every predicted one must appear.
  always @(negedge clk) begin
    bit hit;
    hit = (exp_q.size() > 0) && (exp_q[0].at == cyc);
    if (key_valid || hit) begin
      check("key_valid", 32'(key_valid), 32'(hit));
      if (hit) begin
        check("key_code", 32'(key_code), 32'(exp_q[0].code));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d strobes still pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, r, c, h, ng, l1;
    logic [3:0] mask, colv, last_code;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_bp", 32'(button_pressed), 0);
    check("rst_kv", 32'(key_valid), 0);
    check("rst_code", 32'(key_code), 0);
    reset = 1'b0;
    drive(4'b0000, 4'b0010, 3);

    // Key 8: press latency and release latency.
    t0 = cyc + 1;
    row_keys = 4'b0100;
    expect_strobe(t0 + D + 2, key_of(2, 1));
    at_cyc(t0 + 1);
    check("bp_before_edge2", 32'(button_pressed), 0);
    at_cyc(t0 + 2);
    check("bp_after_edge2", 32'(button_pressed), 1);
    at_cyc(t0 + D + 3);
    s = cyc + 1;
    row_keys = 4'b0000;
    at_cyc(s + D + 1);
    check("bp_release_hold", 32'(button_pressed), 1);
    at_cyc(s + D + 2);
    check("bp_release_fall", 32'(button_pressed), 0);

    // Short bounce on row 1: debounce entered, then abandoned.
    drive(4'b0010, 4'b0010, 3);
    check("bp_bounce", 32'(button_pressed), 1);
    drive(4'b0000, 4'b0010, D + 4);
    check("bp_bounce_idle", 32'(button_pressed), 0);

    // Key 0 with a release glitch: one strobe, idle D+2 edges after the last low start.
    t0 = cyc + 1;
    expect_strobe(t0 + D + 2, key_of(3, 1));
    drive(4'b1000, 4'b0010, D + 4);
    drive(4'b0000, 4'b0010, 1);
    drive(4'b1000, 4'b0010, 2);
    s = cyc + 1;
    row_keys = 4'b0000;
    at_cyc(s + D + 1);
    check("bp_glitch_hold", 32'(button_pressed), 1);
    at_cyc(s + D + 2);
    check("bp_glitch_fall", 32'(button_pressed), 0);

    // Lowest row wins; invalid columns are ignored.
    t0 = cyc + 1;
    expect_strobe(t0 + D + 2, 4'hB);
    drive(4'b1010, 4'b1000, D + 4);
    drive(4'b0000, 4'b1000, D + 4);
    check("code_hold_B", 32'(key_code), 32'hB);
    drive(4'b1111, 4'b0000, D + 6);
    check("no_col_idle", 32'(button_pressed), 0);
    drive(4'b1111, 4'b0110, D + 6);
    check("multi_col_idle", 32'(button_pressed), 0);
    drive(4'b0000, 4'b0001, 3);

    // Reset during DEBOUNCE.
    drive(4'b0001, 4'b0001, 4);
    check("deb_bp_pre", 32'(button_pressed), 1);
    reset = 1'b1;
    #1;
    check("rst_deb_bp", 32'(button_pressed), 0);
    check("rst_deb_kv", 32'(key_valid), 0);
    check("rst_deb_code", 32'(key_code), 0);
    row_keys = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b0000, 4'b0001, 3);
    check("rst_deb_idle", 32'(button_pressed), 0);

    // Reset during HELD.
    t0 = cyc + 1;
    expect_strobe(t0 + D + 2, key_of(1, 1));
    drive(4'b0010, 4'b0010, D + 4);
    check("held_code_pre", 32'(key_code), 32'h5);
    reset = 1'b1;
    #1;
    check("rst_held_bp", 32'(button_pressed), 0);
    check("rst_held_kv", 32'(key_valid), 0);
    check("rst_held_code", 32'(key_code), 0);
    row_keys = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(4'b0000, 4'b0010, 3);
    check("rst_held_idle", 32'(button_pressed), 0);
    last_code = 4'h0;

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: +10 after the first strobe, then every 5 cycles.
    t0 = cyc + 1;
    expect_strobe(t0 + D + 2, key_of(0, 2));
    for (int k = 0; k < 5; k++) expect_strobe(t0 + D + 2 + 10 + 5 * k, key_of(0, 2));
    drive(4'b0001, 4'b0100, 36);
    drive(4'b0000, 4'b0100, D + 4);
    check("repeat_idle", 32'(button_pressed), 0);
    last_code = key_of(0, 2);
`endif

    // Randomized presses with pre-press bounces, extra rows while held, and release bounces.
    for (int it = 0; it < 24; it++) begin
      r    = int'($urandom_range(0, 3));
      c    = int'($urandom_range(0, 3));
      mask = (4'b0001 << r) | (4'($urandom) & (4'hE << r));
      colv = 4'b0001 << c;

      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) colv = 4'b0000;
        else do colv = 4'($urandom); while ($countones(colv) < 2);
        drive(mask, colv, D + 6);
        check("rand_badcol_idle", 32'(button_pressed), 0);
        drive(4'b0000, 4'b0001, 3);
        continue;
      end

      ng = int'($urandom_range(0, 2));
      for (int g = 0; g < ng; g++) begin
        drive(mask, colv, int'($urandom_range(1, D - 1)));
        drive(4'b0000, colv, int'($urandom_range(2, 4)));
      end

      h  = int'($urandom_range(D + 2, D + 8));
      t0 = cyc + 1;
      expect_strobe(t0 + D + 2, key_of(r, c));
      drive(mask, colv, D + 2);
      for (int k = D + 2; k < h; k++) drive((4'b0001 << r) | 4'($urandom), colv, 1);
      check("rand_bp_held", 32'(button_pressed), 1);

      l1 = int'($urandom_range(1, 3));
      drive(4'b0000, colv, l1);
      if ($urandom_range(0, 1) == 1)
        drive((4'b0001 << r) | 4'($urandom), colv, int'($urandom_range(1, 2)));
      drive(4'b0000, colv, D + 4);
      last_code = key_of(r, c);
      check("rand_bp_idle", 32'(button_pressed), 0);
      check("rand_code_hold", 32'(key_code), 32'(last_code));
    end

    drive(4'b0000, 4'b0001, 10);
    check("pending_strobes", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
